// File: rtl/local_inject_ctrl_pkg.sv
// Shared constants and FSM state encoding for the router Local-port packet injector.
package local_inject_ctrl_pkg;

    localparam int TAM_FLIT   = 16;
    localparam int METADEFLIT = TAM_FLIT / 2;
    localparam int LOCAL      = 4;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HEADER  = 3'd1,
        S_SIZE    = 3'd2,
        S_PAYLOAD = 3'd3,
        S_DONE    = 3'd4
    } inj_state_e;

endpackage

// File: rtl/local_inject_ctrl_rr_arbiter.sv
// Combinational round-robin picker: grants the first requester at or after ptr, wrapping.
module rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int PTR_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  grant
);

    logic             w_found;
    logic [PTR_W:0]   w_pos;

    // Circular scan starting at ptr; ptr is always below NREQ so one wrap suffices.
    always_comb begin
        grant   = {NREQ{1'b0}};
        w_found = 1'b0;
        w_pos   = {(PTR_W+1){1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            w_pos = {1'b0, ptr} + (PTR_W+1)'(i);
            if (w_pos >= (PTR_W+1)'(NREQ)) begin
                w_pos = w_pos - (PTR_W+1)'(NREQ);
            end else begin
                w_pos = w_pos;
            end
            if (!w_found && req[w_pos[PTR_W-1:0]]) begin
                grant[w_pos[PTR_W-1:0]] = 1'b1;
                w_found                 = 1'b1;
            end else begin
                w_found = w_found;
            end
        end
    end

endmodule

// File: rtl/local_inject_ctrl.sv
// Arbitrates NREQ packet sources onto one router Local input port and serialises
// each packet as header, size and payload flits under credit flow control.
module local_inject_ctrl #(
    parameter int NREQ     = 4,
    parameter int TAM_FLIT = local_inject_ctrl_pkg::TAM_FLIT
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_i,
    input  logic [NREQ*TAM_FLIT-1:0] target_i,
    input  logic [NREQ*TAM_FLIT-1:0] size_i,
    input  logic [NREQ*TAM_FLIT-1:0] pld_data_i,
    input  logic [NREQ-1:0]          pld_valid_i,
    output logic [NREQ-1:0]          pld_pop_o,
    output logic [NREQ-1:0]          grant_o,
    output logic [NREQ-1:0]          done_o,
    output logic                     tx_o,
    output logic [TAM_FLIT-1:0]      data_o,
    input  logic                     credit_i,
    output logic                     busy_o,
    output logic [15:0]              pkt_count_o
);

    import local_inject_ctrl_pkg::*;

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [TAM_FLIT-1:0] w_target [NREQ];
    logic [TAM_FLIT-1:0] w_size   [NREQ];
    logic [TAM_FLIT-1:0] w_pld    [NREQ];

    logic [NREQ-1:0]     w_arb_grant;
    logic [PTR_W-1:0]    w_arb_idx;
    logic                w_any_req;
    logic                w_tx;
    logic [TAM_FLIT-1:0] w_data;
    logic                w_xfer;
    logic [NREQ-1:0]     w_pop;

    inj_state_e          r_state;
    logic [PTR_W-1:0]    r_rr_ptr;
    logic [PTR_W-1:0]    r_gnt_idx;
    logic [TAM_FLIT-1:0] r_target;
    logic [TAM_FLIT-1:0] r_size;
    logic [TAM_FLIT-1:0] r_cnt;
    logic [NREQ-1:0]     r_grant;
    logic [NREQ-1:0]     r_done;
    logic                r_busy;
    logic [15:0]         r_pkt_count;

    for (genvar k = 0; k < NREQ; k++) begin : g_slice
        assign w_target[k] = target_i[k*TAM_FLIT +: TAM_FLIT];
        assign w_size[k]   = size_i[k*TAM_FLIT +: TAM_FLIT];
        assign w_pld[k]    = pld_data_i[k*TAM_FLIT +: TAM_FLIT];
    end

    rr_arbiter #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .req   (req_i),
        .ptr   (r_rr_ptr),
        .grant (w_arb_grant)
    );

    assign w_any_req = |req_i;

    // One-hot arbiter grant to binary source index.
    always_comb begin
        w_arb_idx = {PTR_W{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            if (w_arb_grant[i]) begin
                w_arb_idx = PTR_W'(i);
            end else begin
                w_arb_idx = w_arb_idx;
            end
        end
    end

    // Flit presented to the router; payload passes straight through so that valid
    // and data always belong to the same cycle as the pop they cause.
    always_comb begin
        w_tx   = 1'b0;
        w_data = {TAM_FLIT{1'b0}};
        case (r_state)
            S_HEADER: begin
                w_tx   = 1'b1;
                w_data = r_target;
            end
            S_SIZE: begin
                w_tx   = 1'b1;
                w_data = r_size;
            end
            S_PAYLOAD: begin
                w_tx   = pld_valid_i[r_gnt_idx];
                w_data = w_pld[r_gnt_idx];
            end
            default: begin
                w_tx   = 1'b0;
                w_data = {TAM_FLIT{1'b0}};
            end
        endcase
    end

    assign w_xfer = w_tx & credit_i;
    assign w_pop  = (r_state == S_PAYLOAD && w_xfer) ? r_grant : {NREQ{1'b0}};

    // Packet sequencing FSM with its registered status outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= {PTR_W{1'b0}};
            r_gnt_idx   <= {PTR_W{1'b0}};
            r_target    <= {TAM_FLIT{1'b0}};
            r_size      <= {TAM_FLIT{1'b0}};
            r_cnt       <= {TAM_FLIT{1'b0}};
            r_grant     <= {NREQ{1'b0}};
            r_done      <= {NREQ{1'b0}};
            r_busy      <= 1'b0;
            r_pkt_count <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= {NREQ{1'b0}};
                    if (w_any_req) begin
                        r_state   <= S_HEADER;
                        r_gnt_idx <= w_arb_idx;
                        r_grant   <= w_arb_grant;
                        r_target  <= w_target[w_arb_idx];
                        r_size    <= w_size[w_arb_idx];
                        r_busy    <= 1'b1;
                        r_rr_ptr  <= (w_arb_idx == PTR_W'(NREQ - 1)) ? {PTR_W{1'b0}}
                                                                     : w_arb_idx + PTR_W'(1);
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_HEADER: begin
                    if (w_xfer) begin
                        r_state <= S_SIZE;
                    end else begin
                        r_state <= S_HEADER;
                    end
                end
                S_SIZE: begin
                    if (w_xfer) begin
                        r_cnt <= r_size;
                        if (r_size == {TAM_FLIT{1'b0}}) begin
                            r_state     <= S_DONE;
                            r_done      <= r_grant;
                            r_grant     <= {NREQ{1'b0}};
                            r_pkt_count <= r_pkt_count + 16'd1;
                        end else begin
                            r_state <= S_PAYLOAD;
                        end
                    end else begin
                        r_state <= S_SIZE;
                    end
                end
                S_PAYLOAD: begin
                    if (w_xfer) begin
                        r_cnt <= r_cnt - TAM_FLIT'(1);
                        if (r_cnt == TAM_FLIT'(1)) begin
                            r_state     <= S_DONE;
                            r_done      <= r_grant;
                            r_grant     <= {NREQ{1'b0}};
                            r_pkt_count <= r_pkt_count + 16'd1;
                        end else begin
                            r_state <= S_PAYLOAD;
                        end
                    end else begin
                        r_state <= S_PAYLOAD;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= {NREQ{1'b0}};
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_grant <= {NREQ{1'b0}};
                    r_done  <= {NREQ{1'b0}};
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign tx_o        = w_tx;
    assign data_o      = w_data;
    assign pld_pop_o   = w_pop;
    assign grant_o     = r_grant;
    assign done_o      = r_done;
    assign busy_o      = r_busy;
    assign pkt_count_o = r_pkt_count;

endmodule

// File: tb/tb_local_inject_ctrl.sv
// Randomised and directed bench for local_inject_ctrl against a packet-position reference model.
module tb_local_inject_ctrl;

    localparam int N = 4;
    localparam int W = 16;

    logic           clock = 1'b0;
    logic           reset = 1'b0;
    logic [N-1:0]   req_i = '0;
    logic [N*W-1:0] target_i = '0;
    logic [N*W-1:0] size_i = '0;
    logic [N*W-1:0] pld_data_i = '0;
    logic [N-1:0]   pld_valid_i = '0;
    logic [N-1:0]   pld_pop_o;
    logic [N-1:0]   grant_o;
    logic [N-1:0]   done_o;
    logic           tx_o;
    logic [W-1:0]   data_o;
    logic           credit_i = 1'b1;
    logic           busy_o;
    logic [15:0]    pkt_count_o;

    always #5 clock = ~clock;

    local_inject_ctrl #(.NREQ(N), .TAM_FLIT(W)) dut (
        .clock(clock), .reset(reset), .req_i(req_i), .target_i(target_i),
        .size_i(size_i), .pld_data_i(pld_data_i), .pld_valid_i(pld_valid_i),
        .pld_pop_o(pld_pop_o), .grant_o(grant_o), .done_o(done_o), .tx_o(tx_o),
        .data_o(data_o), .credit_i(credit_i), .busy_o(busy_o), .pkt_count_o(pkt_count_o)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: a packet is a list of flits indexed by position
    // 0 = header, 1 = size, 2..sz+1 = payload, sz+2 = completion cycle.
    bit           m_active;
    int           m_pos, m_src, m_sz, m_rr, m_count;
    logic [W-1:0] m_tgt;

    logic         e_tx, e_busy;
    logic [W-1:0] e_data;
    logic [N-1:0] e_pop, e_grant, e_done;

    logic         s_tx, s_xfer;
    logic [W-1:0] s_data;
    logic [N-1:0] s_grant;
    int           a_xfers, a_pops;
    logic [N-1:0] a_done;
    int           cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0; m_pos = 0; m_src = 0; m_sz = 0; m_rr = 0; m_count = 0; m_tgt = '0;
    endtask

    task automatic expect_now();
        logic [N-1:0] oh;
        e_tx = 1'b0; e_data = '0; e_pop = '0; e_grant = '0; e_done = '0; e_busy = 1'b0;
        oh = N'(1 << m_src);
        if (m_active) begin
            e_busy = 1'b1;
            if (m_pos == 0) begin
                e_tx = 1'b1; e_data = m_tgt; e_grant = oh;
            end else if (m_pos == 1) begin
                e_tx = 1'b1; e_data = W'(m_sz); e_grant = oh;
            end else if (m_pos < m_sz + 2) begin
                e_tx = pld_valid_i[m_src];
                e_data = pld_data_i[m_src*W +: W];
                e_grant = oh;
                if (e_tx && credit_i) e_pop = oh;
            end else begin
                e_done = oh;
            end
        end
    endtask

    task automatic check_outputs();
        chk("tx_o", 32'(tx_o), 32'(e_tx));
        chk("data_o", 32'(data_o), 32'(e_data));
        chk("pld_pop_o", 32'(pld_pop_o), 32'(e_pop));
        chk("grant_o", 32'(grant_o), 32'(e_grant));
        chk("done_o", 32'(done_o), 32'(e_done));
        chk("busy_o", 32'(busy_o), 32'(e_busy));
        chk("pkt_count_o", 32'(pkt_count_o), 32'(m_count));
    endtask

    task automatic model_advance();
        bit found;
        if (!m_active) begin
            if (req_i != '0) begin
                found = 1'b0;
                for (int i = 0; i < N; i++) begin
                    int k;
                    k = (m_rr + i) % N;
                    if (!found && req_i[k]) begin
                        found = 1'b1;
                        m_src = k;
                    end
                end
                m_tgt = target_i[m_src*W +: W];
                m_sz = int'(size_i[m_src*W +: W]);
                m_rr = (m_src + 1) % N;
                m_active = 1'b1;
                m_pos = 0;
            end
        end else if (m_pos == m_sz + 2) begin
            m_active = 1'b0;
        end else if (e_tx && credit_i) begin
            m_pos++;
            if (m_pos == m_sz + 2) m_count = (m_count + 1) % 65536;
        end
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic step();
        #1;
        expect_now();
        check_outputs();
        s_tx = tx_o; s_xfer = tx_o & credit_i; s_data = data_o; s_grant = grant_o;
        if (s_xfer) a_xfers++;
        a_pops += $countones(pld_pop_o);
        a_done |= done_o;
        model_advance();
        cyc++;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset();
        #2 reset = 1'b0;
        model_reset();
        #1;
        expect_now();
        check_outputs();
        chk("async_rst_busy", 32'(busy_o), 32'd0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic clear_acc();
        a_xfers = 0; a_pops = 0; a_done = '0;
    endtask

    task automatic run_until_pos(input int p, input int budget);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (m_active && m_pos == p) begin
                hit = 1'b1;
                break;
            end
            step();
            if (m_active) req_i = '0;
        end
        chk("wait_pos_timeout", 32'(hit), 32'd1);
    endtask

    task automatic run_until_idle(input int budget);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (!m_active) begin
                hit = 1'b1;
                break;
            end
            step();
        end
        chk("wait_idle_timeout", 32'(hit), 32'd1);
    endtask

    initial begin
        logic [W-1:0] log_d [8];
        int           log_c [8];
        int           nlog;
        logic [N-1:0] gseq [5];
        int           ng;
        logic [N-1:0] prev_g;
        int           pj;

        model_reset();
        clear_acc();
        @(negedge clock);
        #1;
        expect_now();
        check_outputs();
        reset = 1'b1;
        @(negedge clock);

        // Single packet from source 0: 0x0102, size 3, three payload flits.
        req_i = 4'b0001; credit_i = 1'b1; pld_valid_i = 4'b1111;
        target_i[0 +: W] = 16'h0102; size_i[0 +: W] = 16'd3;
        nlog = 0; clear_acc();
        for (int i = 0; i < 9; i++) begin
            pld_data_i[0 +: W] = 16'hA000 + ((m_active && m_pos >= 2) ? W'(m_pos - 2) : 16'h0000);
            step();
            if (s_xfer && nlog < 8) begin
                log_d[nlog] = s_data; log_c[nlog] = cyc; nlog++;
            end
            if (m_active) begin
                req_i = '0; target_i[0 +: W] = 16'hFFFF; size_i[0 +: W] = 16'd9;
            end
        end
        chk("p35_nflits", 32'(nlog), 32'd5);
        chk("p35_hdr", 32'(log_d[0]), 32'h0102);
        chk("p35_size", 32'(log_d[1]), 32'h0003);
        chk("p35_p0", 32'(log_d[2]), 32'hA000);
        chk("p35_p1", 32'(log_d[3]), 32'hA001);
        chk("p35_p2", 32'(log_d[4]), 32'hA002);
        chk("p35_consecutive", 32'(log_c[4] - log_c[0]), 32'd4);
        chk("p35_done", 32'(a_done), 32'b0001);
        chk("p35_count", 32'(pkt_count_o), 32'd1);

        // All four sources requesting: round-robin order 0,1,2,3,0.
        do_reset();
        req_i = 4'b1111; size_i = '0; target_i = 64'h0004_0003_0002_0001;
        ng = 0; prev_g = '0;
        for (int i = 0; i < 40 && ng < 5; i++) begin
            step();
            if (s_grant != '0 && prev_g == '0) begin
                gseq[ng] = s_grant; ng++;
            end
            prev_g = s_grant;
        end
        chk("p36_ngrants", 32'(ng), 32'd5);
        chk("p36_g0", 32'(gseq[0]), 32'b0001);
        chk("p36_g1", 32'(gseq[1]), 32'b0010);
        chk("p36_g2", 32'(gseq[2]), 32'b0100);
        chk("p36_g3", 32'(gseq[3]), 32'b1000);
        chk("p36_g4", 32'(gseq[4]), 32'b0001);
        req_i = '0;
        run_until_idle(20);

        // Credit withheld for five cycles while the size flit is presented.
        req_i = 4'b0010; target_i[W +: W] = 16'h0A0B; size_i[W +: W] = 16'd2; clear_acc();
        run_until_pos(1, 10);
        credit_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("p37_tx_held", 32'(s_tx), 32'd1);
            chk("p37_data_held", 32'(s_data), 32'h0002);
        end
        chk("p37_no_pop", 32'(a_pops), 32'd0);
        credit_i = 1'b1;
        run_until_idle(20);
        chk("p37_pops", 32'(a_pops), 32'd2);
        chk("p37_done", 32'(a_done), 32'b0010);

        // Zero-length packet from source 2.
        req_i = 4'b0100; target_i[2*W +: W] = 16'h0304; size_i[2*W +: W] = 16'd0; clear_acc();
        run_until_pos(0, 10);
        run_until_idle(20);
        chk("p38_flits", 32'(a_xfers), 32'd2);
        chk("p38_pops", 32'(a_pops), 32'd0);
        chk("p38_done", 32'(a_done), 32'b0100);

        // Payload valid toggling 1,0,1,0 on a two-flit payload.
        req_i = 4'b0001; size_i[0 +: W] = 16'd2; clear_acc();
        run_until_pos(2, 10);
        pj = 0;
        for (int i = 0; i < 20 && m_active; i++) begin
            pld_valid_i[0] = (pj % 2 == 0);
            step();
            pj++;
        end
        pld_valid_i = 4'b1111;
        chk("p40_pops", 32'(a_pops), 32'd2);
        chk("p40_done", 32'(a_done), 32'b0001);
        chk("p40_cycles", 32'(pj), 32'd4);

        // Reset while the second of four payload flits is presented.
        req_i = 4'b0010; target_i[W +: W] = 16'h0506; size_i[W +: W] = 16'd4; clear_acc();
        run_until_pos(3, 12);
        req_i = 4'b0010;
        do_reset();
        step();
        step();
        chk("p39_hdr_tx", 32'(s_tx), 32'd1);
        chk("p39_hdr_data", 32'(s_data), 32'h0506);
        chk("p39_no_done", 32'(a_done), 32'd0);

        // Randomised traffic with periodic resets.
        for (int i = 0; i < 2100; i++) begin
            req_i = ($urandom_range(0, 9) < 7) ? N'($urandom_range(0, 15)) : '0;
            for (int k = 0; k < N; k++) begin
                target_i[k*W +: W] = W'($urandom);
                size_i[k*W +: W] = W'($urandom_range(0, 5));
                pld_data_i[k*W +: W] = W'($urandom);
            end
            pld_valid_i = N'($urandom) | N'($urandom);
            credit_i = ($urandom_range(0, 3) != 0);
            if (i % 700 == 350) do_reset();
            else step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
